// File: rtl/mul_rr_arbiter_pkg.sv
// Shared definitions for the round-robin multiplier arbiter: default operand
// widths, the full-product width and the round-robin grant-select function.
package mul_rr_arbiter_pkg;

    // Largest supported requester count and the index width that covers it
    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    // Default operand widths and the resulting full signed product width
    localparam int DIN0_WIDTH = 3;
    localparam int DIN1_WIDTH = 2;
    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

    // Result of one arbitration pass: whether anyone won, and who
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } grant_t;

    // Full signed product width for arbitrary operand widths
    function automatic int prod_width(input int aWidth, input int bWidth);
        return aWidth + bWidth;
    endfunction

    // Round-robin pick: the request vector is viewed as rotated so the entry
    // just after lastGrant comes first, priority-encoded, and the winning
    // position is mapped back to a requester index. Scanning from the far end
    // toward the near end lets the nearest active requester overwrite others.
    function automatic grant_t grant_select(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        lastGrant,
        input int unsigned        numReq
    );
        grant_t      g;
        int unsigned idx;
        g = '0;
        for (int unsigned k = MAX_REQ; k >= 1; k--) begin
            if (k <= numReq) begin
                idx = lastGrant + k;
                if (idx >= numReq) begin
                    idx = idx - numReq;
                end
                if (valid[idx[IDX_W-1:0]]) begin
                    g.found = 1'b1;
                    g.idx   = idx[IDX_W-1:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mul_rr_arbiter_mul.sv
// Combinational signed multiplier with two's-complement resize of the result:
// narrower outputs keep the low bits, wider outputs are sign-extended.
module mul_rr_arbiter_mul
    import mul_rr_arbiter_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_WIDTH,
    parameter int din1_WIDTH = DIN1_WIDTH,
    parameter int dout_WIDTH = 4
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);

    logic signed [PW-1:0] w_fullProduct;

    // Both operands are sign-extended to the full width so the product is exact
    assign w_fullProduct = PW'($signed(din0)) * PW'($signed(din1));

    // A signed size cast truncates or sign-extends as the widths require
    assign dout = dout_WIDTH'(w_fullProduct);

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ requesters.
// The winning operands are multiplied and registered into a one-entry result
// slot tagged with the requester index; drained results are counted.
module mul_rr_arbiter
    import mul_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int din0_WIDTH = DIN0_WIDTH,
    parameter int din1_WIDTH = DIN1_WIDTH,
    parameter int dout_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*din0_WIDTH-1:0] req_din0,
    input  logic [NUM_REQ*din1_WIDTH-1:0] req_din1,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [dout_WIDTH-1:0]         res_dout,
    output logic [ID_WIDTH-1:0]           res_id,
    output logic [CNT_WIDTH-1:0]          res_count
);

    logic                  r_resValid;
    logic [dout_WIDTH-1:0] r_resDout;
    logic [ID_WIDTH-1:0]   r_resId;
    logic [CNT_WIDTH-1:0]  r_resCount;
    logic [ID_WIDTH-1:0]   r_lastGrant;

    logic                  w_slotFree;
    logic                  w_drain;
    logic [MAX_REQ-1:0]    w_validExt;
    grant_t                w_sel;
    logic                  w_grant;
    logic [ID_WIDTH-1:0]   w_grantId;
    logic [din0_WIDTH-1:0] w_din0;
    logic [din1_WIDTH-1:0] w_din1;
    logic [dout_WIDTH-1:0] w_product;

    // The slot can take a new result when empty or being drained this cycle;
    // nothing is accepted while reset is asserted
    assign w_slotFree = ap_rst_n && (!r_resValid || res_ready);
    assign w_drain    = r_resValid && res_ready;
    assign w_validExt = MAX_REQ'(req_valid);

    // Round-robin selection starting just after the previous winner
    always_comb begin
        w_sel     = grant_select(w_validExt, 32'(r_lastGrant), NUM_REQ);
        w_grant   = w_slotFree && w_sel.found;
        w_grantId = ID_WIDTH'(w_sel.idx);
    end

    // Drive the one-hot accept and route the winner's operands to the multiplier
    always_comb begin
        req_ready = '0;
        w_din0    = '0;
        w_din1    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant && (w_sel.idx == IDX_W'(i))) begin
                req_ready[i] = 1'b1;
                w_din0       = req_din0[i*din0_WIDTH +: din0_WIDTH];
                w_din1       = req_din1[i*din1_WIDTH +: din1_WIDTH];
            end
        end
    end

    mul_rr_arbiter_mul #(
        .din0_WIDTH (din0_WIDTH),
        .din1_WIDTH (din1_WIDTH),
        .dout_WIDTH (dout_WIDTH)
    ) u_mul (
        .din0 (w_din0),
        .din1 (w_din1),
        .dout (w_product)
    );

    // Result slot, round-robin pointer and drain counter
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_resValid  <= 1'b0;
            r_resDout   <= '0;
            r_resId     <= '0;
            r_resCount  <= '0;
            r_lastGrant <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            if (w_drain) begin
                r_resCount <= r_resCount + CNT_WIDTH'(1);
            end
            if (w_grant) begin
                r_resValid  <= 1'b1;
                r_resDout   <= w_product;
                r_resId     <= w_grantId;
                r_lastGrant <= w_grantId;
            end else if (w_drain) begin
                r_resValid <= 1'b0;
            end
        end
    end

    assign res_valid = r_resValid;
    assign res_dout  = r_resDout;
    assign res_id    = r_resId;
    assign res_count = r_resCount;

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Self-checking bench for mul_rr_arbiter: a reference model predicts grants
// and products, queues expected results and compares them as the slot drains.
module tb_mul_rr_arbiter;

    localparam int NREQ = 4;
    // A narrow counter keeps the wrap-around scenario short
    localparam int CNTW = 8;

    typedef struct packed {
        logic [3:0] dout;
        logic [1:0] id;
    } exp_t;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*3-1:0] req_din0;
    logic [NREQ*2-1:0] req_din1;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [3:0]      res_dout;
    logic [1:0]      res_id;
    logic [CNTW-1:0] res_count;

    logic signed [2:0] opA [NREQ];
    logic signed [1:0] opB [NREQ];

    exp_t            expQ[$];
    int              mLast;
    bit              mValid;
    logic [CNTW-1:0] mCount;
    int              testCount = 0;
    int              failCount = 0;

    mul_rr_arbiter #(
        .NUM_REQ    (NREQ),
        .ID_WIDTH   (2),
        .din0_WIDTH (3),
        .din1_WIDTH (2),
        .dout_WIDTH (4),
        .CNT_WIDTH  (CNTW)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_dout  (res_dout),
        .res_id    (res_id),
        .res_count (res_count)
    );

    always #5 ap_clk = ~ap_clk;

    // Pack per-requester operands onto the flat buses
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_din0[i*3 +: 3] = opA[i];
            req_din1[i*2 +: 2] = opB[i];
        end
    end

    function automatic logic [3:0] mulModel(input int a, input int b);
        logic [31:0] p;
        p = a * b;
        return p[3:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        testCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy);
        req_valid = valid;
        res_ready = rdy;
    endtask

    task automatic setOps(input int idx, input logic signed [2:0] a, input logic signed [1:0] b);
        opA[idx] = a;
        opB[idx] = b;
    endtask

    // One clock: check outputs against the model at the falling edge, then
    // advance the model to match what the rising edge will do
    task automatic stepCycle(input string tag);
        logic [NREQ-1:0] expReady;
        int   g;
        int   idx;
        exp_t e;
        @(negedge ap_clk);
        expReady = '0;
        g = -1;
        if (ap_rst_n && (!mValid || res_ready)) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (mLast + k) % NREQ;
                if (req_valid[idx] && g < 0) g = idx;
            end
            if (g >= 0) expReady[g] = 1'b1;
        end
        checkOutput({tag, "/req_ready"}, 32'(req_ready), 32'(expReady));
        checkOutput({tag, "/res_valid"}, 32'(res_valid), 32'(mValid));
        checkOutput({tag, "/res_count"}, 32'(res_count), 32'(mCount));
        if (mValid && expQ.size() > 0) begin
            checkOutput({tag, "/res_dout"}, 32'(res_dout), 32'(expQ[0].dout));
            checkOutput({tag, "/res_id"}, 32'(res_id), 32'(expQ[0].id));
        end
        if (!ap_rst_n) begin
            mValid = 1'b0;
            mLast  = NREQ - 1;
            mCount = '0;
            expQ.delete();
        end else begin
            if (mValid && res_ready) begin
                void'(expQ.pop_front());
                mValid = 1'b0;
                mCount = mCount + 1'b1;
            end
            if (g >= 0) begin
                e.dout = mulModel(int'(opA[g]), int'(opB[g]));
                e.id   = 2'(g);
                expQ.push_back(e);
                mValid = 1'b1;
                mLast  = g;
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    // Directed scenario sequence
    initial begin
        int guard;
        mValid = 1'b0;
        mLast  = NREQ - 1;
        mCount = '0;
        setOps(0, 3'sd1, -2'sd1);
        setOps(1, -3'sd2, 2'sd1);
        setOps(2, 3'sd3, -2'sd2);
        setOps(3, -3'sd3, -2'sd1);

        // Reset with every requester asking: nothing may be accepted
        ap_rst_n = 1'b0;
        applyStimulus(4'hF, 1'b1);
        @(posedge ap_clk);
        #1;
        stepCycle("reset0");
        stepCycle("reset1");
        ap_rst_n = 1'b1;

        // Round-robin: 0,1,2,3,0,1 with all requesters active
        for (int i = 0; i < 6; i++) stepCycle("rr");
        applyStimulus(4'h0, 1'b1);
        stepCycle("rr_drain");
        stepCycle("idle");

        // Basic multiply: 3 * -2 = -6
        setOps(0, 3'sd3, -2'sd2);
        applyStimulus(4'h1, 1'b1);
        stepCycle("basic");
        checkOutput("basic_dout_const", 32'(res_dout), 32'h0000000A);
        checkOutput("basic_id_const", 32'(res_id), 32'h0);
        applyStimulus(4'h0, 1'b1);
        stepCycle("basic_drain");

        // Backpressure: result pending, downstream stalls for five cycles
        applyStimulus(4'hF, 1'b1);
        stepCycle("bp_fill");
        applyStimulus(4'hF, 1'b0);
        for (int i = 0; i < 5; i++) stepCycle("bp_hold");
        applyStimulus(4'hF, 1'b1);
        stepCycle("bp_release");
        checkOutput("bp_refill_valid", 32'(res_valid), 32'h1);
        applyStimulus(4'h0, 1'b1);
        stepCycle("bp_drain");
        stepCycle("bp_idle");

        // Width wrap: -4 * -2 = +8 wraps to 4'b1000
        setOps(0, -3'sd4, -2'sd2);
        applyStimulus(4'h1, 1'b1);
        stepCycle("wrap");
        checkOutput("wrap_dout_const", 32'(res_dout), 32'h00000008);
        applyStimulus(4'h0, 1'b1);
        stepCycle("wrap_drain");

        // Counter wrap: keep draining until the count rolls over
        applyStimulus(4'hF, 1'b1);
        guard = 0;
        while (mCount != {CNTW{1'b1}} && guard < 400) begin
            stepCycle("cnt_run");
            guard++;
        end
        if (guard >= 400) begin
            checkOutput("cnt_run_timeout", 32'(guard), 32'h0);
        end
        stepCycle("cnt_wrap");
        checkOutput("cnt_wrap_const", 32'(res_count), 32'h0);

        // Reset mid-operation while a result is held under backpressure
        applyStimulus(4'h4, 1'b1);
        stepCycle("mid_fill");
        applyStimulus(4'h4, 1'b0);
        stepCycle("mid_hold");
        ap_rst_n = 1'b0;
        stepCycle("mid_reset");
        ap_rst_n = 1'b1;
        applyStimulus(4'hF, 1'b1);
        stepCycle("mid_after");
        checkOutput("mid_after_id", 32'(res_id), 32'h0);
        stepCycle("mid_next");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
